instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage feeding the control unit and decoder. Holds the PC, requests 19-bit instruction words from instruction memory over a req/ack handshake, and buffers one fetched word with its PC.
- Presents the buffered word to decode with a valid/ready handshake.
- Accepts PC redirects for jump and taken branch from downstream. Stops fetching after a HALT word.

Parameters:
PC_W, 8, PC/instruction-address width in words
RESET_PC, 0, PC value loaded on reset
HALT_WORD, 19'h7FFFF, instruction encoding that halts fetch
CNT_W, 16, width of saturating fetch counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request (level; held until ack or cancel)
imem_addr  out  PC_W  word address of request (= pc)
imem_ack  in  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  in  19  instruction word
instr_valid  out  1  buffered instruction available to decode
instr  out  19  buffered instruction (type=[18:17], code=[16:15], funct=[2:0])
instr_pc  out  PC_W  address instr was fetched from
decode_ready  in  1  decode consumes instr this cycle when instr_valid
redirect_valid  in  1  single-cycle pulse: flush and load redirect_pc
redirect_pc  in  PC_W  new fetch address
halted  out  1  fetch stopped on HALT_WORD
fetch_count  out  CNT_W  instructions delivered to decode, saturating

Behaviour:
- Reset (rst_n=0, async) sets:
  - pc=RESET_PC; state=RUN; buf_valid=0; instr=0; instr_pc=0; halted=0; fetch_count=0.
  - imem_req=0 while in reset.
- States:
  - RUN: fetching.
  - HALTED: no requests issued; halted=1.
- imem_req = (state==RUN) && !redirect_valid && (!buf_valid || decode_ready).
  - Combinational from decode_ready and redirect_valid.
- imem_addr = pc at all times.
- Memory handshake:
  - Transfer occurs when imem_req && imem_ack.
  - Ack may arrive in the same cycle as req or any later cycle.
  - A cycle with imem_req=0 cancels the outstanding request. Memory must not ack a deasserted req.
- On transfer:
  - instr<=imem_rdata; instr_pc<=pc; buf_valid<=1; pc<=pc+1.
  - PC increment wraps modulo 2^PC_W.
- instr_valid = buf_valid && !redirect_valid.
- Handoff occurs when instr_valid && decode_ready.
  - On handoff with no simultaneous transfer: buf_valid<=0.
  - On handoff with a simultaneous transfer: the buffer is overwritten, buf_valid stays 1. Sustained throughput is one instruction per cycle with zero-latency memory.
  - Each handoff increments fetch_count, saturating at 2^CNT_W-1.
- HALT:
  - On transfer of imem_rdata==HALT_WORD, the word is still buffered and delivered normally, and state<=HALTED.
  - No further requests are made; pc keeps the value after the halt word.
- Redirect (priority over transfer and handoff):
  - pc<=redirect_pc; buf_valid<=0; state<=RUN; halted<=0.
  - Any ack in that cycle is ignored because req is low.
  - No handoff occurs and fetch_count does not change.
  - Redirect in HALTED resumes fetching at redirect_pc the next cycle.
- Backpressure:
  - With buf_valid=1 and decode_ready=0, imem_req=0.
  - instr and instr_pc stay stable and instr_valid stays high until handoff or redirect.
- Reset mid-request: imem_req drops immediately (async); the outstanding request is cancelled.

Test Plan:
- Reset then release, zero-latency memory returning mem[a]=a+0x100, decode_ready=1 -> imem_addr 0,1,2,... on consecutive cycles; instr 0x100,0x101,... with instr_pc 0,1,...; one valid per cycle; fetch_count counts up.
- Ack delayed 2 cycles per request -> imem_req held with stable imem_addr for 3 cycles; each instr delivered once; no duplicates or skips.
- decode_ready=0 for 4 cycles with buffer full -> imem_req=0, instr/instr_pc stable, fetch_count frozen. Raise ready -> next fetch issued that same cycle.
- Redirect to 0x40 while a delayed request to 0x05 is outstanding and the buffer holds 0x04 -> instr_valid=0 that cycle, 0x04 never counted, next request addr 0x40, first delivered instr_pc=0x40.
- Memory word at 0x03 = 19'h7FFFF -> word at 0x03 delivered, halted=1, imem_req stays 0 for 10 cycles. Redirect to 0x10 -> halted=0, fetch resumes at 0x10.
- CNT_W=4, deliver 20 instructions -> fetch_count stops at 15. pc at 0xFF increments to 0x00 (wrap).

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory, one-entry
// instruction buffer presented to decode with valid/ready, redirects and halt.
module instr_fetch #(
  parameter int unsigned     PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [18:0]     HALT_WORD = 19'h7FFFF,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [18:0]      imem_rdata,
  output logic             instr_valid,
  output logic [18:0]      instr,
  output logic [PC_W-1:0]  instr_pc,
  input  logic             decode_ready,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned INSTR_W = 19;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0]     fetch_count_q, fetch_count_d;

  logic req_c;
  logic xfer_c;
  logic handoff_c;

  // Request is gated by rst_n so it drops the moment reset asserts.
  always_comb begin
    req_c     = rst_n && (state_q == ST_RUN) && !redirect_valid
                && (!buf_valid_q || decode_ready);
    xfer_c    = req_c && imem_ack;
    handoff_c = buf_valid_q && !redirect_valid && decode_ready;
  end

  // Next-state logic; redirect overrides both transfer and handoff.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_valid_d   = buf_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      buf_valid_d = 1'b0;
      state_d     = ST_RUN;
    end else begin
      if (handoff_c) begin
        buf_valid_d = 1'b0;
        if (fetch_count_q != CNT_MAX) begin
          fetch_count_d = fetch_count_q + CNT_W'(1);
        end
      end
      // A same-cycle transfer refills the buffer after the handoff drains it.
      if (xfer_c) begin
        instr_d     = imem_rdata;
        instr_pc_d  = pc_q;
        buf_valid_d = 1'b1;
        pc_d        = pc_q + PC_W'(1);
        if (imem_rdata == HALT_WORD) begin
          state_d = ST_HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      buf_valid_q   <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_valid_q   <= buf_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = req_c;
  assign imem_addr   = pc_q;
  assign instr_valid = buf_valid_q && !redirect_valid;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = fetch_count_q;

endmodule
